// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file parameters, requester enum and address helper
package regfile_pkg;

    localparam int NUM_REGS   = 8;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 4;
    localparam int CNT_WIDTH  = 2;
    localparam int IDX_WIDTH  = $clog2(NUM_REGS);

    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return a < NUM_REGS_A;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - write-back request channel (valid/ready with address and data)
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic                  valid;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/reg_pending_counter.sv
// rtl/reg_pending_counter.sv - saturating up/down counter of in-flight writes for one register
module reg_pending_counter #(
    parameter int WIDTH = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic nonzero,
    output logic overflow
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] count;

    assign nonzero  = count != '0;
    assign overflow = inc & ~dec & (count == MAX);

    // Simultaneous inc and dec cancel; underflow silently holds at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc & ~dec & (count != MAX)) begin
            count <= count + 1'b1;
        end else if (dec & ~inc & (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-port arbiter with pending-write hazard scoreboard
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    regfile_wb_arbiter_if.slave   alu,
    regfile_wb_arbiter_if.slave   mem,
    input  logic                  mark_valid,
    input  logic [ADDR_WIDTH-1:0] mark_addr,
    input  logic [ADDR_WIDTH-1:0] query_addr1,
    input  logic [ADDR_WIDTH-1:0] query_addr2,
    output logic                  hazard1,
    output logic                  hazard2,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  err
);

    req_e                  prio;
    logic                  alu_grant;
    logic                  mem_grant;
    logic                  accepted;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_REGS-1:0]   nonzero;
    logic [NUM_REGS-1:0]   overflow;

    assign alu_grant = alu.valid & (~mem.valid | (prio == REQ_ALU));
    assign mem_grant = mem.valid & (~alu.valid | (prio == REQ_MEM));

    assign alu.ready = alu_grant & ~reset;
    assign mem.ready = mem_grant & ~reset;
    assign accepted  = alu.ready | mem.ready;

    assign sel_addr = mem.ready ? mem.addr : alu.addr;
    assign sel_data = mem.ready ? mem.data : alu.data;

    always_ff @(posedge clock) begin
        if (reset) begin
            write         <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            prio          <= REQ_ALU;
            err           <= 1'b0;
        end else begin
            write <= accepted & addr_ok(sel_addr);
            if (accepted & addr_ok(sel_addr)) begin
                write_address <= sel_addr;
                write_data    <= sel_data;
            end
            if (alu.ready) begin
                prio <= REQ_MEM;
            end else if (mem.ready) begin
                prio <= REQ_ALU;
            end
            if ((accepted & ~addr_ok(sel_addr)) | (mark_valid & ~addr_ok(mark_addr)) | (|overflow)) begin
                err <= 1'b1;
            end
        end
    end

    // The decrement is keyed off the registered write pulse, so a hazard clears
    // on the same edge the register file captures the data.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cnt
        reg_pending_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
            .clock    (clock),
            .reset    (reset),
            .inc      (mark_valid & (mark_addr == ADDR_WIDTH'(i))),
            .dec      (write & (write_address == ADDR_WIDTH'(i))),
            .nonzero  (nonzero[i]),
            .overflow (overflow[i])
        );
    end

    assign hazard1 = addr_ok(query_addr1) & nonzero[query_addr1[IDX_WIDTH-1:0]];
    assign hazard2 = addr_ok(query_addr2) & nonzero[query_addr2[IDX_WIDTH-1:0]];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized and directed bench against a behavioural model
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  mark_valid = 1'b0;
    logic [ADDR_WIDTH-1:0] mark_addr = '0;
    logic [ADDR_WIDTH-1:0] query_addr1 = '0;
    logic [ADDR_WIDTH-1:0] query_addr2 = '0;
    logic                  hazard1, hazard2, write, err;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0] write_data;

    regfile_wb_arbiter_if alu ();
    regfile_wb_arbiter_if mem ();

    always #5 clock = ~clock;

    regfile_wb_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .alu           (alu),
        .mem           (mem),
        .mark_valid    (mark_valid),
        .mark_addr     (mark_addr),
        .query_addr1   (query_addr1),
        .query_addr2   (query_addr2),
        .hazard1       (hazard1),
        .hazard2       (hazard2),
        .write         (write),
        .write_address (write_address),
        .write_data    (write_data),
        .err           (err)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: who gets the next tie, in-flight counts, pending write, sticky error.
    bit        m_mem_turn;
    int        m_cnt [NUM_REGS];
    bit        m_write;
    int        m_waddr;
    int        m_wdata;
    bit        m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_hazard(input int q);
        return (q < NUM_REGS) ? (m_cnt[q] != 0) : 1'b0;
    endfunction

    task automatic model_reset();
        m_mem_turn = 1'b0;
        m_write    = 1'b0;
        m_waddr    = 0;
        m_wdata    = 0;
        m_err      = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) m_cnt[i] = 0;
    endtask

    task automatic cyc(input bit rst,
                       input bit av, input int aa, input int ad,
                       input bit mv, input int ma, input int md,
                       input bit kv, input int ka,
                       input int q1, input int q2);
        bit ag, mg;
        int inc_r, dec_r;
        @(negedge clock);
        reset       = rst;
        alu.valid   = av;
        alu.addr    = ADDR_WIDTH'(aa);
        alu.data    = DATA_WIDTH'(ad);
        mem.valid   = mv;
        mem.addr    = ADDR_WIDTH'(ma);
        mem.data    = DATA_WIDTH'(md);
        mark_valid  = kv;
        mark_addr   = ADDR_WIDTH'(ka);
        query_addr1 = ADDR_WIDTH'(q1);
        query_addr2 = ADDR_WIDTH'(q2);
        #1;
        if (av && mv) begin
            ag = !m_mem_turn;
            mg = m_mem_turn;
        end else begin
            ag = av;
            mg = mv;
        end
        if (rst) begin
            ag = 1'b0;
            mg = 1'b0;
        end
        check("alu_ready", alu.ready, ag);
        check("mem_ready", mem.ready, mg);
        check("hazard1", hazard1, m_hazard(q1));
        check("hazard2", hazard2, m_hazard(q2));

        if (rst) begin
            model_reset();
        end else begin
            inc_r = (kv && ka < NUM_REGS) ? ka : -1;
            dec_r = m_write ? m_waddr : -1;
            if (kv && ka >= NUM_REGS) m_err = 1'b1;
            if (inc_r != dec_r) begin
                if (inc_r >= 0) begin
                    if (m_cnt[inc_r] == 3) m_err = 1'b1;
                    else m_cnt[inc_r]++;
                end
                if (dec_r >= 0 && m_cnt[dec_r] > 0) m_cnt[dec_r]--;
            end
            m_write = 1'b0;
            if (ag || mg) begin
                int a, d;
                a = ag ? aa : ma;
                d = ag ? ad : md;
                m_mem_turn = ag;
                if (a < NUM_REGS) begin
                    m_write = 1'b1;
                    m_waddr = a;
                    m_wdata = d;
                end else begin
                    m_err = 1'b1;
                end
            end
        end

        @(posedge clock);
        #1;
        check("write", write, m_write);
        check("write_address", write_address, m_waddr);
        check("write_data", write_data, m_wdata);
        check("err", err, m_err);
    endtask

    task automatic idle(input int q1, input int q2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, q1, q2);
    endtask

    initial begin
        alu.valid = 1'b0; alu.addr = '0; alu.data = '0;
        mem.valid = 1'b0; mem.addr = '0; mem.data = '0;
        model_reset();

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 16'h1111, 1, 2, 16'h2222, 1, 3, 0, 0);
        for (int i = 0; i < 16; i++) idle(i, 15 - i);

        // Both producers contend: grants alternate starting with ALU.
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 16'h1111, 1, 2, 16'h2222, 0, 0, 1, 2);
        idle(1, 2);

        // Two marks on 3, then two load writes to 3.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
        cyc(0, 0, 0, 0, 1, 3, 16'h3333, 0, 0, 3, 0);
        cyc(0, 0, 0, 0, 1, 3, 16'h3334, 0, 0, 3, 0);
        idle(3, 0);
        idle(3, 0);
        check("hazard3_cleared", hazard1, 1'b0);

        // Mark coinciding with the write pulse on 5 leaves the count at 1.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
        cyc(0, 0, 0, 0, 1, 5, 16'h5555, 0, 0, 5, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
        idle(5, 0);
        check("hazard5_held", hazard1, 1'b1);

        // Four marks on 6 overflow the counter.
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 6, 6, 6);
        check("err_overflow", err, 1'b1);

        // Invalid destination consumed without a pulse.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 9, 16'h9999, 0, 0, 0, 0, 0, 12, 9);
        check("err_bad_addr", err, 1'b1);
        idle(12, 9);

        // Reset right after an accept discards the write and restores ALU priority.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 4, 16'h4444, 0, 0, 0, 1, 4, 4, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        idle(4, 0);
        cyc(0, 1, 7, 16'h7777, 1, 0, 16'h0abc, 0, 0, 4, 7);
        idle(7, 0);

        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 2) != 0), $urandom_range(0, 9), $urandom_range(0, 16'hffff),
                ($urandom_range(0, 2) != 0), $urandom_range(0, 9), $urandom_range(0, 16'hffff),
                ($urandom_range(0, 2) == 0), $urandom_range(0, 8),
                $urandom_range(0, 15), $urandom_range(0, 15));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
